// File: rtl/fht_pkg.sv
// fht_pkg
// Shared constants, state encoding and helpers for the FHT address and
// sequencing controller.
//   A_BIT     : bank address width (bank holds 2^A_BIT points)
//   BANK_SIZE : points per bank
//   STAGES    : number of transform stages (log2 of the total point count)
//   PIPE      : read-to-write latency of the butterfly datapath, in cycles
//   bitrev()  : reverses the low w bits of a value (stage-0 read ordering)
package fht_pkg;

    localparam int A_BIT     = 8;
    localparam int BANK_SIZE = 1 << A_BIT;
    localparam int STAGES    = A_BIT + 2;
    localparam int PIPE      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fht_state_t;

    // Reverse bit order of the low w bits of v; bits at and above w come out 0.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[w - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// fht_delay_line
// Fixed-depth shift register that carries the registered read addresses and
// their per-bank-set valid bits forward to the write side of the datapath.
//   clk  : clock
//   srst : synchronous active-high reset, clears every stage
//   din  : word entering the line
//   dout : din as it was DEPTH cycles earlier
module fht_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] pipe_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign dout = pipe_reg[DEPTH-1];

endmodule

// File: rtl/fht_ctrl.sv
// fht_ctrl
// Address and sequencing controller for a ping-pong, four-bank fast Hartley
// transform. A start pulse runs STAGES stages of BANK_SIZE+PIPE cycles each.
//   iCLK, iRESET            : clock, synchronous active-high reset
//   iSTART                  : start request, honoured only while idle
//   oADDR_RD_0..3           : per-bank read addresses
//   oADDR_WR_0..3           : per-bank write addresses (reads delayed PIPE)
//   oADDR_COEF              : twiddle ROM address
//   oWE_A, oWE_B            : write enables for bank set A / B
//   oSOURCE_DATA            : datapath reads set B when 1, set A when 0
//   oSOURCE_CONT            : transform owns RAM control while running
//   oST_ZERO, oST_LAST      : first / last stage flags
//   o2ND_PART_SUBSEC        : read index lies in the upper half of its sub-sector
//   oSECTOR                 : sub-sector index of the read index
//   oRDY                    : idle / done
// Every output is a register updated the cycle after the counter value it
// describes.
module fht_ctrl #(
    parameter int A_BIT  = fht_pkg::A_BIT,
    parameter int STAGES = A_BIT + 2,
    parameter int PIPE   = fht_pkg::PIPE,
    parameter int S_BIT  = $clog2(STAGES)
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic [A_BIT-1:0] oADDR_COEF,
    output logic             oWE_A,
    output logic             oWE_B,
    output logic             oSOURCE_DATA,
    output logic             oSOURCE_CONT,
    output logic             oST_ZERO,
    output logic             oST_LAST,
    output logic             o2ND_PART_SUBSEC,
    output logic [A_BIT-1:0] oSECTOR,
    output logic             oRDY
);

    import fht_pkg::*;

    localparam int BANK_LEN  = 1 << A_BIT;
    localparam int STAGE_LEN = BANK_LEN + PIPE;
    localparam int T_BIT     = $clog2(STAGE_LEN);
    localparam int DL_W      = 4 * A_BIT + 2;

    localparam logic [T_BIT-1:0] T_LAST     = T_BIT'(STAGE_LEN - 1);
    localparam logic [T_BIT-1:0] T_BANK     = T_BIT'(BANK_LEN);
    localparam logic [S_BIT-1:0] STAGE_LAST = S_BIT'(STAGES - 1);

    // ---------------- state and counters ----------------
    fht_state_t       state_reg, state_next;
    logic [S_BIT-1:0] stage_reg, stage_next;
    logic [T_BIT-1:0] time_reg,  time_next;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_reg <= ST_IDLE;
            stage_reg <= '0;
            time_reg  <= '0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            time_reg  <= time_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        time_next  = time_reg;
        case (state_reg)
            ST_IDLE: begin
                if (iSTART) begin
                    state_next = ST_RUN;
                    stage_next = '0;
                    time_next  = '0;
                end
            end
            ST_RUN: begin
                if (time_reg == T_LAST) begin
                    time_next = '0;
                    if (stage_reg == STAGE_LAST) begin
                        // Counters return to 0 so the idle flags match reset.
                        state_next = ST_IDLE;
                        stage_next = '0;
                    end else begin
                        stage_next = stage_reg + S_BIT'(1);
                    end
                end else begin
                    time_next = time_reg + T_BIT'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    logic             run, rd_phase;
    logic [A_BIT-1:0] t, neg_t, mask, partner, br, sub_bits;
    logic [31:0]      sh, br_full;

    logic [A_BIT-1:0] rd_next [4];
    logic [A_BIT-1:0] coef_next, sector_next;
    logic             sub_next, va_next, vb_next;
    logic             rdy_next, src_data_next, src_cont_next, st_zero_next, st_last_next;

    always_comb begin
        run      = (state_reg == ST_RUN);
        rd_phase = run && (time_reg < T_BANK);
        t        = time_reg[A_BIT-1:0];
        // Butterfly span grows with the stage and saturates at the bank width.
        sh       = (32'(stage_reg) > 32'(A_BIT)) ? 32'(A_BIT) : 32'(stage_reg);
        mask     = A_BIT'((32'd1 << sh) - 32'd1);
        neg_t    = '0 - t;
        // Reflected partner: keep the sector bits, negate the in-sector offset.
        partner  = (t & ~mask) | (neg_t & mask);
        br_full  = bitrev(32'(t), A_BIT);
        br       = br_full[A_BIT-1:0];
        sub_bits = t >> (sh - 32'd1);

        for (int k = 0; k < 4; k++) begin
            rd_next[k] = '0;
        end
        coef_next     = '0;
        sector_next   = '0;
        sub_next      = 1'b0;
        va_next       = 1'b0;
        vb_next       = 1'b0;
        rdy_next      = !run;
        src_data_next = run && stage_reg[0];
        src_cont_next = run;
        st_zero_next  = (stage_reg == '0);
        st_last_next  = run && (stage_reg == STAGE_LAST);

        if (rd_phase) begin
            // Even stages read set A and write set B; odd stages the reverse.
            va_next = stage_reg[0];
            vb_next = !stage_reg[0];
            if (stage_reg == '0) begin
                for (int k = 0; k < 4; k++) begin
                    rd_next[k] = br;
                end
                sector_next = t;
            end else begin
                rd_next[0]  = t;
                rd_next[1]  = t;
                rd_next[2]  = partner;
                rd_next[3]  = partner;
                coef_next   = A_BIT'(32'(t & mask) << (32'(A_BIT) - sh));
                sector_next = t >> sh;
                sub_next    = (32'(stage_reg) <= 32'(A_BIT)) ? sub_bits[0] : 1'b0;
            end
        end
    end

    // ---------------- output registers ----------------
    logic [A_BIT-1:0] rd_reg [4];
    logic [A_BIT-1:0] coef_reg, sector_reg;
    logic             sub_reg, va_reg, vb_reg;
    logic             rdy_reg, src_data_reg, src_cont_reg, st_zero_reg, st_last_reg;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int k = 0; k < 4; k++) begin
                rd_reg[k] <= '0;
            end
            coef_reg     <= '0;
            sector_reg   <= '0;
            sub_reg      <= 1'b0;
            va_reg       <= 1'b0;
            vb_reg       <= 1'b0;
            rdy_reg      <= 1'b1;
            src_data_reg <= 1'b0;
            src_cont_reg <= 1'b0;
            st_zero_reg  <= 1'b1;
            st_last_reg  <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                rd_reg[k] <= rd_next[k];
            end
            coef_reg     <= coef_next;
            sector_reg   <= sector_next;
            sub_reg      <= sub_next;
            va_reg       <= va_next;
            vb_reg       <= vb_next;
            rdy_reg      <= rdy_next;
            src_data_reg <= src_data_next;
            src_cont_reg <= src_cont_next;
            st_zero_reg  <= st_zero_next;
            st_last_reg  <= st_last_next;
        end
    end

    // ---------------- write side ----------------
    // The read-side valid bits travel with the addresses, so a write enable
    // can only appear PIPE cycles after a genuine read of the same stage.
    logic [DL_W-1:0] dl_in, dl_out;

    assign dl_in = {va_reg, vb_reg, rd_reg[3], rd_reg[2], rd_reg[1], rd_reg[0]};

    fht_delay_line #(
        .W     (DL_W),
        .DEPTH (PIPE)
    ) u_delay (
        .clk  (iCLK),
        .srst (iRESET),
        .din  (dl_in),
        .dout (dl_out)
    );

    assign oWE_A      = dl_out[DL_W-1];
    assign oWE_B      = dl_out[DL_W-2];
    assign oADDR_WR_3 = dl_out[4*A_BIT-1 -: A_BIT];
    assign oADDR_WR_2 = dl_out[3*A_BIT-1 -: A_BIT];
    assign oADDR_WR_1 = dl_out[2*A_BIT-1 -: A_BIT];
    assign oADDR_WR_0 = dl_out[A_BIT-1 -: A_BIT];

    assign oADDR_RD_0       = rd_reg[0];
    assign oADDR_RD_1       = rd_reg[1];
    assign oADDR_RD_2       = rd_reg[2];
    assign oADDR_RD_3       = rd_reg[3];
    assign oADDR_COEF       = coef_reg;
    assign oSECTOR          = sector_reg;
    assign o2ND_PART_SUBSEC = sub_reg;
    assign oSOURCE_DATA     = src_data_reg;
    assign oSOURCE_CONT     = src_cont_reg;
    assign oST_ZERO         = st_zero_reg;
    assign oST_LAST         = st_last_reg;
    assign oRDY             = rdy_reg;

endmodule

// File: tb/tb_fht_ctrl.sv
// tb_fht_ctrl
// Directed bench for fht_ctrl with A_BIT=8, PIPE=4 (stage length 260 cycles,
// 10 stages). Sample index n counts edges after the start edge: the sample
// taken 1 time unit after edge k+1+n shows stage n/260, time n%260.
module tb_fht_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef, sector;
    logic       we_a, we_b, src_data, src_cont, st_zero, st_last, sub, rdy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fht_ctrl dut (
        .iCLK             (clk),
        .iRESET           (rst),
        .iSTART           (start),
        .oADDR_RD_0       (rd0),
        .oADDR_RD_1       (rd1),
        .oADDR_RD_2       (rd2),
        .oADDR_RD_3       (rd3),
        .oADDR_WR_0       (wr0),
        .oADDR_WR_1       (wr1),
        .oADDR_WR_2       (wr2),
        .oADDR_WR_3       (wr3),
        .oADDR_COEF       (coef),
        .oWE_A            (we_a),
        .oWE_B            (we_b),
        .oSOURCE_DATA     (src_data),
        .oSOURCE_CONT     (src_cont),
        .oST_ZERO         (st_zero),
        .oST_LAST         (st_last),
        .o2ND_PART_SUBSEC (sub),
        .oSECTOR          (sector),
        .oRDY             (rdy)
    );

    // Called 1 time unit after an edge; returns 1 time unit after the start edge.
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0d expected 1", rdy); end
        checks++; if ({we_a, we_b} !== 2'b00) begin errors++; $display("FAIL reset_we: got %0d expected 0", {we_a, we_b}); end
        checks++; if ({rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3} !== 64'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", {rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3}); end
        checks++; if ({coef, sector, sub, src_data, src_cont, st_last} !== 20'd0) begin errors++; $display("FAIL reset_misc: got %0h expected 0", {coef, sector, sub, src_data, src_cont, st_last}); end
        checks++; if (st_zero !== 1'b1) begin errors++; $display("FAIL reset_st_zero: got %0d expected 1", st_zero); end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rdy !== 1'b1 || we_a !== 1'b0 || we_b !== 1'b0 || src_cont !== 1'b0 ||
                {rd0, rd1, rd2, rd3, wr0, wr1, wr2, wr3, coef} !== 72'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad); end
        $display("test_idle done");
    endtask

    task automatic test_full_run();
        int n, low, wea_st1, web_st1, srcbad_st1, both;
        n = 0; low = 0; wea_st1 = 0; web_st1 = 0; srcbad_st1 = 0; both = 0;
        start_pulse();
        while (n < 3000) begin
            @(posedge clk); #1;
            if (rdy === 1'b1) break;
            low++;
            if (we_a === 1'b1 && we_b === 1'b1) both++;
            if (n >= 260 && n < 520) begin
                if (we_a === 1'b1) wea_st1++;
                if (we_b === 1'b1) web_st1++;
                if (src_data !== 1'b1) srcbad_st1++;
            end
            // A second start while running must be ignored.
            if (n == 1000) start = 1'b1;
            if (n == 1001) start = 1'b0;
            case (n)
                0: begin
                    checks++; if (st_zero !== 1'b1) begin errors++; $display("FAIL s0_st_zero: got %0d expected 1", st_zero); end
                    checks++; if (src_cont !== 1'b1) begin errors++; $display("FAIL s0_src_cont: got %0d expected 1", src_cont); end
                end
                1: begin
                    checks++; if ({rd0, rd1, rd2, rd3} !== {4{8'd128}}) begin errors++; $display("FAIL s0_t1_rd: got %0h expected 80808080", {rd0, rd1, rd2, rd3}); end
                end
                3: begin
                    checks++; if ({rd0, rd1, rd2, rd3} !== {4{8'd192}}) begin errors++; $display("FAIL s0_t3_rd: got %0h expected c0c0c0c0", {rd0, rd1, rd2, rd3}); end
                end
                5: begin
                    checks++; if ({wr0, wr1, wr2, wr3} !== {4{8'd128}}) begin errors++; $display("FAIL s0_t5_wr: got %0h expected 80808080", {wr0, wr1, wr2, wr3}); end
                    checks++; if ({we_a, we_b} !== 2'b01) begin errors++; $display("FAIL s0_t5_we: got %0b expected 01", {we_a, we_b}); end
                end
                256: begin
                    checks++; if (rd0 !== 8'd0) begin errors++; $display("FAIL s0_t256_rd_idle: got %0d expected 0", rd0); end
                end
                260: begin
                    checks++; if (st_zero !== 1'b0) begin errors++; $display("FAIL s1_st_zero: got %0d expected 0", st_zero); end
                end
                526: begin // stage 2, t=6
                    checks++; if ({rd2, coef, sector, sub} !== {8'd6, 8'd128, 8'd1, 1'b1}) begin errors++; $display("FAIL s2_t6: got rd2=%0d coef=%0d sector=%0d sub=%0d expected 6 128 1 1", rd2, coef, sector, sub); end
                end
                785: begin // stage 3, t=5
                    checks++; if ({rd0, rd1, rd2, rd3} !== {8'd5, 8'd5, 8'd3, 8'd3}) begin errors++; $display("FAIL s3_t5_rd: got %0d %0d %0d %0d expected 5 5 3 3", rd0, rd1, rd2, rd3); end
                    checks++; if ({coef, sector, sub, src_data} !== {8'd160, 8'd0, 1'b1, 1'b1}) begin errors++; $display("FAIL s3_t5_misc: got coef=%0d sector=%0d sub=%0d src=%0d expected 160 0 1 1", coef, sector, sub, src_data); end
                end
                2339: begin // stage 8, t=259
                    checks++; if (st_last !== 1'b0) begin errors++; $display("FAIL s8_st_last: got %0d expected 0", st_last); end
                end
                2340: begin
                    checks++; if (st_last !== 1'b1) begin errors++; $display("FAIL s9_st_last: got %0d expected 1", st_last); end
                end
                2440: begin // stage 9, t=100
                    checks++; if ({rd0, rd2, coef, sector, sub} !== {8'd100, 8'd156, 8'd100, 8'd0, 1'b0}) begin errors++; $display("FAIL s9_t100: got rd0=%0d rd2=%0d coef=%0d sector=%0d sub=%0d expected 100 156 100 0 0", rd0, rd2, coef, sector, sub); end
                end
                2599: begin // last write of the transform
                    checks++; if ({we_a, we_b, wr0, wr2} !== {1'b1, 1'b0, 8'd255, 8'd1}) begin errors++; $display("FAIL s9_last_write: got we=%0b%0b wr0=%0d wr2=%0d expected 10 255 1", we_a, we_b, wr0, wr2); end
                end
                default: ;
            endcase
            n++;
        end
        checks++; if (low !== 2600) begin errors++; $display("FAIL busy_cycles: got %0d expected 2600", low); end
        checks++; if ({rdy, we_a, we_b, src_cont, st_zero} !== 5'b10001) begin errors++; $display("FAIL done_state: got %0b expected 10001", {rdy, we_a, we_b, src_cont, st_zero}); end
        checks++; if (wea_st1 !== 256 || web_st1 !== 0) begin errors++; $display("FAIL s1_we_count: got we_a=%0d we_b=%0d expected 256 0", wea_st1, web_st1); end
        checks++; if (srcbad_st1 !== 0) begin errors++; $display("FAIL s1_source_data: got %0d bad cycles expected 0", srcbad_st1); end
        checks++; if (both !== 0) begin errors++; $display("FAIL we_both_high: got %0d cycles expected 0", both); end
        $display("test_full_run done");
    endtask

    task automatic test_abort_reset();
        int bad;
        bad = 0;
        start_pulse();
        repeat (1050) @(posedge clk);   // sample n=1049: stage 4
        #1;
        checks++; if ({rdy, st_zero, src_cont} !== 3'b001) begin errors++; $display("FAIL abort_pre: got %0b expected 001", {rdy, st_zero, src_cont}); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({rdy, st_zero, we_a, we_b, src_cont, src_data} !== 6'b110000) begin errors++; $display("FAIL abort_flags: got %0b expected 110000", {rdy, st_zero, we_a, we_b, src_cont, src_data}); end
        checks++; if ({rd0, rd2, wr0, wr2, coef, sector} !== 48'd0) begin errors++; $display("FAIL abort_addr: got %0h expected 0", {rd0, rd2, wr0, wr2, coef, sector}); end
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (we_a !== 1'b0 || we_b !== 1'b0 || rdy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d bad cycles expected 0", bad); end
        start_pulse();
        @(posedge clk); #1;
        @(posedge clk); #1;             // n=1: stage 0, t=1
        checks++; if ({rd0, rd2, st_zero, src_data, rdy} !== {8'd128, 8'd128, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL restart: got rd0=%0d rd2=%0d st_zero=%0d src=%0d rdy=%0d expected 128 128 1 0 0", rd0, rd2, st_zero, src_data, rdy); end
        $display("test_abort_reset done");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_full_run();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
